rotate_right_seq: RTL and testbench

- Iterative 16-bit rotate-right execution unit for the ALU. It is the inverse-direction counterpart of the ALU's combinational rotate-left.
- Rotates by one bit position per clock, under a start/busy/done handshake.
- Produces a registered result plus Z/N/C/V flags in the ALU flag convention, so the flags feed the status register directly.

---
 rtl/rotate_right_seq_if.sv | 37 +++
 rtl/rotate_right_seq.sv | 136 +++++++++++++
 tb/tb_rotate_right_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rotate_right_seq_if.sv
// Purpose : request/response bundle for the iterative rotate-right unit.
// Latency : n/a (wires only).
// Backpressure: none; start is only honoured when the unit is IDLE or DONE.
//
// Ports (master = requester, slave = rotate unit):
//   start  - request, sampled on the rising clock edge
//   j, k   - operand and rotate-right amount, captured on the accepting edge
//   busy   - unit is rotating
//   done   - one-cycle pulse, result/flags valid from this cycle
//   result - registered rotate-right of j by k
//   Z, N   - zero / negative flags of result
//   C, V   - carry / overflow flags, always 0 for rotations
interface rotate_right_seq_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] j;
  logic [AMT_W-1:0] k;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             Z;
  logic             N;
  logic             C;
  logic             V;

  modport master (
    output start, j, k,
    input  busy, done, result, Z, N, C, V
  );

  modport slave (
    input  start, j, k,
    output busy, done, result, Z, N, C, V
  );
endinterface

// File: rtl/rotate_right_seq.sv
// Purpose : iterative WIDTH-bit rotate-right, one bit position per clock, ALU flags.
// Latency : k+1 busy cycles after the accepting edge; done pulses in the cycle after.
// Backpressure: start ignored while busy; accepted in IDLE or in the DONE cycle.
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - rotate_right_seq_if slave modport (start/j/k in, busy/done/result/Z/N/C/V out)
module rotate_right_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rotate_right_seq_if.slave bus
);

  // The counter must cover exactly one full turn, otherwise k could either
  // fall short of WIDTH-1 or wrap past a full rotation.
  if (WIDTH != (1 << AMT_W)) begin : g_bad_width
    $error("rotate_right_seq: WIDTH must equal 2**AMT_W");
  end
  if ($bits(bus.j) != WIDTH || $bits(bus.k) != AMT_W) begin : g_bad_if
    $error("rotate_right_seq: interface widths do not match module parameters");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] cnt_nxt;

  // Architectural outputs: only rewritten on entry to DONE so they stay
  // readable through IDLE and through the following operation.
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_nxt;
  logic             z_q;
  logic             z_nxt;
  logic             n_q;
  logic             n_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers; a reset abandons any rotation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work     <= '0;
      cnt      <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      work     <= work_nxt;
      cnt      <= cnt_nxt;
      result_q <= result_nxt;
      z_q      <= z_nxt;
      n_q      <= n_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt  = state;
    work_nxt   = work;
    cnt_nxt    = cnt;
    result_nxt = result_q;
    z_nxt      = z_q;
    n_nxt      = n_q;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          work_nxt  = bus.j;
          cnt_nxt   = bus.k;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        // j/k/start are not looked at here; the operands were captured
        // on the accepting edge.
        if (cnt != '0) begin
          work_nxt = {work[0], work[WIDTH-1:1]};
          cnt_nxt  = cnt - AMT_W'(1);
        end else begin
          result_nxt = work;
          z_nxt      = (work == '0);
          n_nxt      = work[WIDTH-1];
          state_nxt  = DONE;
        end
      end

      DONE: begin
        // Accepting here gives back-to-back operation with no idle cycle.
        if (bus.start) begin
          work_nxt  = bus.j;
          cnt_nxt   = bus.k;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // busy/done decode straight from the state register, so both are glitch-free
  // and both read 0 while reset is asserted.
  assign bus.busy   = (state == SHIFT);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
  assign bus.Z      = z_q;
  assign bus.N      = n_q;
  // Rotation moves no bit out of the word, so there is no carry or overflow.
  assign bus.C      = 1'b0;
  assign bus.V      = 1'b0;

endmodule

// File: tb/tb_rotate_right_seq.sv
// Purpose : self-checking bench for rotate_right_seq.
// Latency : n/a.
// Backpressure: n/a.
module tb_rotate_right_seq;
  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rotate_right_seq_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  rotate_right_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] r;
    logic        z;
    logic        n;
  } exp_t;

  typedef struct {
    logic [15:0] j;
    logic [3:0]  k;
    logic [15:0] r;
    logic        z;
    logic        n;
  } vec_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_res = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference rotate-right: take the low word of the doubled operand shifted right.
  function automatic logic [15:0] rotr(input logic [15:0] v, input logic [3:0] s);
    logic [31:0] d;
    d = {v, v} >> s;
    return d[15:0];
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done expected=no_done result=%h", bus.result);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_result", {16'h0, bus.result}, {16'h0, e.r});
        check("sb_flags", {28'h0, bus.Z, bus.N, bus.C, bus.V}, {28'h0, e.z, e.n, 2'b00});
      end
    end
  end

  // Samples the current cycle, then advances; stops at the done cycle.
  task automatic wait_done(output int busy_n, output bit seen);
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic op(input logic [15:0] j, input logic [3:0] k, input logic [15:0] er,
                    input logic ez, input logic en, input string tag);
    exp_t e;
    int   busy_n;
    bit   seen;
    e.r = er;
    e.z = ez;
    e.n = en;
    @(negedge clk);
    bus.start = 1'b1;
    bus.j     = j;
    bus.k     = k;
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    // Scramble the operands after capture; they must have no effect.
    bus.j     = ~j;
    bus.k     = ~k;
    check({tag, "_hold"}, {16'h0, bus.result}, {16'h0, last_res});
    wait_done(busy_n, seen);
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done", tag);
      if (sbq.size() > 0) sbq.delete(0);
    end else begin
      check({tag, "_busy"}, busy_n, k + 1);
    end
    last_res = er;
  endtask

  initial begin
    vec_t        vecs[5];
    int          busy_n;
    bit          seen;
    int          dn_cnt;
    exp_t        e;
    logic [15:0] rj;
    logic [3:0]  rk;
    logic [15:0] rr;

    vecs[0] = '{16'h8001, 4'd1,  16'hC000, 1'b0, 1'b1};
    vecs[1] = '{16'h1234, 4'd0,  16'h1234, 1'b0, 1'b0};
    vecs[2] = '{16'h1234, 4'd4,  16'h4123, 1'b0, 1'b0};
    vecs[3] = '{16'h0001, 4'd15, 16'h0002, 1'b0, 1'b0};
    vecs[4] = '{16'h0000, 4'd5,  16'h0000, 1'b1, 1'b0};

    bus.start = 1'b0;
    bus.j     = 16'h0;
    bus.k     = 4'h0;
    rst_n     = 1'b0;

    #2;
    check("reset_outs", {10'h0, bus.busy, bus.done, bus.result, bus.Z, bus.N, bus.C, bus.V}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outs", {10'h0, bus.busy, bus.done, bus.result, bus.Z, bus.N, bus.C, bus.V}, 32'h0);

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      op(vecs[i].j, vecs[i].k, vecs[i].r, vecs[i].z, vecs[i].n, $sformatf("tbl%0d", i));
    end

    // Result and flags persist through IDLE.
    repeat (3) @(negedge clk);
    check("idle_hold_res", {16'h0, bus.result}, {16'h0, last_res});
    check("idle_hold_z", {31'h0, bus.Z}, {31'h0, (last_res == 16'h0)});
    check("idle_not_busy", {30'h0, bus.busy, bus.done}, 32'h0);

    // start during SHIFT is ignored, then held through DONE for back-to-back.
    @(negedge clk);
    bus.start = 1'b1;
    bus.j     = 16'h00F0;
    bus.k     = 4'd3;
    e.r = 16'h001E; e.z = 1'b0; e.n = 1'b0;
    sbq.push_back(e);
    @(negedge clk);
    bus.j = 16'hFFFF;
    bus.k = 4'd2;
    wait_done(busy_n, seen);
    check("ign_done_seen", {31'h0, seen}, 32'h1);
    check("ign_busy", busy_n, 4);
    e.r = 16'hFFFF; e.z = 1'b0; e.n = 1'b1;
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy", {31'h0, bus.busy}, 32'h1);
    check("b2b_hold", {16'h0, bus.result}, 32'h001E);
    wait_done(busy_n, seen);
    check("b2b_done_seen", {31'h0, seen}, 32'h1);
    check("b2b_busy_cycles", busy_n, 3);
    last_res = 16'hFFFF;

    // Asynchronous reset in the middle of a rotation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.j     = 16'hABCD;
    bus.k     = 4'd8;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'h0, bus.busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", {10'h0, bus.busy, bus.done, bus.result, bus.Z, bus.N, bus.C, bus.V}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 16'h0;
    dn_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) dn_cnt++;
    end
    check("no_done_after_reset", dn_cnt, 0);
    op(16'hABCD, 4'd8, 16'hCDAB, 1'b0, 1'b1, "rst_fresh");

    // Random sweep against the reference model.
    for (int n = 0; n < 1000; n++) begin
      rj = 16'($urandom);
      rk = 4'($urandom_range(0, 15));
      rr = rotr(rj, rk);
      op(rj, rk, rr, (rr == 16'h0), rr[15], "rnd");
    end

    repeat (2) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
